// File: rtl/minirisc_pkg.sv
// Shared KGPminiRISC datapath constants and types used by the immediate-select stage.
package minirisc_pkg;

   // Native immediate width and the full datapath width it can be widened to.
   localparam int IMM_W = 17;
   localparam int EXT_W = 32;

   typedef logic [IMM_W-1:0] imm_t;

   // Meaning of instruction bit 27 when choosing the immediate source.
   typedef enum logic {
      SEL_ITYPE = 1'b0,
      SEL_MEM   = 1'b1
   } imm_sel_e;

endpackage : minirisc_pkg

// File: rtl/mux_imm_sext.sv
// Purely combinational sign-extender: widens an immediate by replicating its top bit.
module imm_sext #(
   parameter int IN_W  = 17,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  i_val,
   output logic [OUT_W-1:0] o_val
);

   assign o_val = {{(OUT_W-IN_W){i_val[IN_W-1]}}, i_val};

endmodule : imm_sext

// File: rtl/mux_imm.sv
// Immediate-select stage: picks the memory-type or I-type immediate using instruction
// bit 27 and registers it, with a one-cycle valid qualifier, for the ALU/address stage.
// Optional build macro MUX_IMM_SEXT_EN adds a registered sign-extended copy (imm_ext).
module mux_imm
   import minirisc_pkg::*;
#(
   parameter int IMM_W = minirisc_pkg::IMM_W
`ifdef MUX_IMM_SEXT_EN
   ,
   parameter int EXT_W = minirisc_pkg::EXT_W
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IMM_W-1:0] mem_type,
   input  logic [IMM_W-1:0] I_type,
   input  logic             I27,
   input  logic             in_valid,
   output logic [IMM_W-1:0] imm,
   output logic             sel_mem,
`ifdef MUX_IMM_SEXT_EN
   output logic [EXT_W-1:0] imm_ext,
`endif
   output logic             out_valid
);

   logic [IMM_W-1:0] w_next_imm;
   logic [IMM_W-1:0] r_imm;
   logic             r_sel_mem;
   logic             r_out_valid;

   // A ternary keeps the unselected source fully isolated, while an unknown select
   // still yields an unknown result rather than silently picking one side.
   assign w_next_imm = (I27 == SEL_MEM) ? mem_type : I_type;

   // Pipeline register: capture on valid, otherwise hold data and drop the qualifier.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_imm       <= {IMM_W{1'b0}};
         r_sel_mem   <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (in_valid) begin
         r_imm       <= w_next_imm;
         r_sel_mem   <= I27;
         r_out_valid <= 1'b1;
      end else begin
         r_imm       <= r_imm;
         r_sel_mem   <= r_sel_mem;
         r_out_valid <= 1'b0;
      end
   end

   assign imm       = r_imm;
   assign sel_mem   = r_sel_mem;
   assign out_valid = r_out_valid;

`ifdef MUX_IMM_SEXT_EN
   logic [EXT_W-1:0] w_next_ext;
   logic [EXT_W-1:0] r_imm_ext;

   imm_sext #(
      .IN_W  (IMM_W),
      .OUT_W (EXT_W)
   ) u_imm_sext (
      .i_val (w_next_imm),
      .o_val (w_next_ext)
   );

   // Extended copy is captured and held exactly like the narrow immediate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_imm_ext <= {EXT_W{1'b0}};
      end else if (in_valid) begin
         r_imm_ext <= w_next_ext;
      end else begin
         r_imm_ext <= r_imm_ext;
      end
   end

   assign imm_ext = r_imm_ext;
`endif

endmodule : mux_imm

// File: tb/tb_mux_imm.sv
// Directed self-checking bench for mux_imm (both builds, keyed on MUX_IMM_SEXT_EN).
`timescale 1ns/1ps
module tb_mux_imm;
   import minirisc_pkg::*;

   logic        clk;
   logic        rst;
   logic [16:0] mem_type;
   logic [16:0] I_type;
   logic        I27;
   logic        in_valid;
   logic [16:0] imm;
   logic        sel_mem;
   logic        out_valid;
`ifdef MUX_IMM_SEXT_EN
   logic [31:0] imm_ext;
`endif

   int n_checks;
   int n_errors;

   mux_imm dut (
      .clk       (clk),
      .rst       (rst),
      .mem_type  (mem_type),
      .I_type    (I_type),
      .I27       (I27),
      .in_valid  (in_valid),
      .imm       (imm),
      .sel_mem   (sel_mem),
`ifdef MUX_IMM_SEXT_EN
      .imm_ext   (imm_ext),
`endif
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; mem_type = 17'd4; I_type = 17'd1; I27 = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks += 3;
      if (imm !== 17'd0) begin n_errors++; $display("FAIL reset_imm got %h want %h", imm, 17'd0); end
      if (sel_mem !== 1'b0) begin n_errors++; $display("FAIL reset_sel got %b want 0", sel_mem); end
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
`ifdef MUX_IMM_SEXT_EN
      n_checks++;
      if (imm_ext !== 32'd0) begin n_errors++; $display("FAIL reset_ext got %h want 0", imm_ext); end
`endif
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks += 3;
      if (imm !== 17'd1) begin n_errors++; $display("FAIL release_imm got %h want %h", imm, 17'd1); end
      if (sel_mem !== 1'b0) begin n_errors++; $display("FAIL release_sel got %b want 0", sel_mem); end
      if (out_valid !== 1'b1) begin n_errors++; $display("FAIL release_valid got %b want 1", out_valid); end
   endtask

   task automatic test_alternate();
      logic        seq [3] = '{1'b0, 1'b1, 1'b0};
      logic [16:0] exp [3] = '{17'd1, 17'd4, 17'd1};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_type = 17'd4; I_type = 17'd1; in_valid = 1'b1; I27 = seq[i];
         @(posedge clk); #1;
         n_checks += 3;
         if (imm !== exp[i]) begin n_errors++; $display("FAIL alt_imm[%0d] got %h want %h", i, imm, exp[i]); end
         if (sel_mem !== seq[i]) begin n_errors++; $display("FAIL alt_sel[%0d] got %b want %b", i, sel_mem, seq[i]); end
         if (out_valid !== 1'b1) begin n_errors++; $display("FAIL alt_valid[%0d] got %b want 1", i, out_valid); end
      end
   endtask

   task automatic test_hold();
      @(negedge clk);
      mem_type = 17'h1ABCD; I_type = 17'h00001; I27 = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (imm !== 17'h1ABCD) begin n_errors++; $display("FAIL hold_capture got %h want %h", imm, 17'h1ABCD); end
      @(negedge clk);
      in_valid = 1'b0; mem_type = 17'h00055; I_type = 17'h00055; I27 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         n_checks += 3;
         if (imm !== 17'h1ABCD) begin n_errors++; $display("FAIL hold_imm[%0d] got %h want %h", i, imm, 17'h1ABCD); end
         if (sel_mem !== 1'b1) begin n_errors++; $display("FAIL hold_sel[%0d] got %b want 1", i, sel_mem); end
         if (out_valid !== 1'b0) begin n_errors++; $display("FAIL hold_valid[%0d] got %b want 0", i, out_valid); end
      end
`ifdef MUX_IMM_SEXT_EN
      n_checks++;
      if (imm_ext !== 32'hFFFF_ABCD) begin n_errors++; $display("FAIL hold_ext got %h want %h", imm_ext, 32'hFFFF_ABCD); end
`endif
   endtask

   task automatic test_full_width();
      @(negedge clk);
      mem_type = 17'h00000; I_type = 17'h1FFFF; I27 = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks += 2;
      if (imm !== 17'h1FFFF) begin n_errors++; $display("FAIL full_imm got %h want %h", imm, 17'h1FFFF); end
      if (out_valid !== 1'b1) begin n_errors++; $display("FAIL full_valid got %b want 1", out_valid); end
`ifdef MUX_IMM_SEXT_EN
      n_checks++;
      if (imm_ext !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL full_ext_neg got %h want %h", imm_ext, 32'hFFFF_FFFF); end
`endif
      @(negedge clk);
      I_type = 17'h0FFFF;
      @(posedge clk); #1;
      n_checks++;
      if (imm !== 17'h0FFFF) begin n_errors++; $display("FAIL full_imm_pos got %h want %h", imm, 17'h0FFFF); end
`ifdef MUX_IMM_SEXT_EN
      n_checks++;
      if (imm_ext !== 32'h0000_FFFF) begin n_errors++; $display("FAIL full_ext_pos got %h want %h", imm_ext, 32'h0000_FFFF); end
`endif
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      mem_type = 17'h00ABC; I_type = 17'h00123; I27 = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || imm !== 17'h00ABC) begin
         n_errors++; $display("FAIL async_pre got imm=%h v=%b want imm=%h v=1", imm, out_valid, 17'h00ABC);
      end
      #2 rst = 1'b1;
      #1;
      n_checks += 3;
      if (imm !== 17'd0) begin n_errors++; $display("FAIL async_imm got %h want 0", imm); end
      if (sel_mem !== 1'b0) begin n_errors++; $display("FAIL async_sel got %b want 0", sel_mem); end
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL async_valid got %b want 0", out_valid); end
      #2 rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (imm !== 17'h00ABC || out_valid !== 1'b1) begin
         n_errors++; $display("FAIL async_recover got imm=%h v=%b want imm=%h v=1", imm, out_valid, 17'h00ABC);
      end
   endtask

   task automatic test_x_isolation();
      @(negedge clk);
      mem_type = 17'bx; I_type = 17'd7; I27 = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks += 2;
      if (imm !== 17'd7) begin n_errors++; $display("FAIL xiso_imm got %h want %h", imm, 17'd7); end
      if ($isunknown(imm)) begin n_errors++; $display("FAIL xiso_unknown got %b want no X", imm); end
      @(negedge clk);
      mem_type = 17'd0; in_valid = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_alternate();
      test_hold();
      test_full_width();
      test_async_reset();
      test_x_isolation();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard time limit so the run always ends even if a task stalls.
   initial begin
      #100000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule : tb_mux_imm

// File: doc/mux_imm.md
Name: mux_imm

Overview:
- Immediate-select stage of the KGPminiRISC datapath.
- Chooses between the memory-type immediate and the I-type immediate, using instruction bit 27.
- Registers the result for the following ALU/address stage.
- One pipeline register, simple valid qualifier, optional 32-bit sign-extended output.

Parameters:
- IMM_W, 17, width of both immediate inputs and of imm.
- EXT_W, 32, width of the sign-extended output (used only when the optional feature is compiled in).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- mem_type  input  IMM_W  immediate field decoded for load/store instructions.
- I_type  input  IMM_W  immediate field decoded for I-type ALU instructions.
- I27  input  1  select, taken from instruction bit 27. 1 selects mem_type; 0 selects I_type.
- in_valid  input  1  inputs are meaningful this cycle.
- imm  output  IMM_W  registered selected immediate.
- sel_mem  output  1  registered copy of the I27 value that produced imm.
- out_valid  output  1  imm and sel_mem hold a freshly captured value.

Behaviour:
- Reset (rst=1, asynchronous, any time):
  - imm=0, sel_mem=0, out_valid=0 immediately, held while rst is high.
  - Reset mid-operation discards the in-flight value.
  - The first capture after release happens at the first rising clk edge with rst=0 and in_valid=1.
- Selection (combinational, internal):
  - next_imm = I27 ? mem_type : I_type.
  - Full IMM_W width, no truncation or extension.
- Capture, every rising clk edge with rst=0:
  - in_valid=1: imm<=next_imm, sel_mem<=I27, out_valid<=1.
  - in_valid=0: imm and sel_mem hold their previous values; out_valid<=0.
- Latency:
  - Exactly 1 cycle from input to imm.
  - Throughput: one selection per cycle, no backpressure.
- Data and select:
  - X or Z on the unselected input must never propagate to imm.
  - If I27 is X while in_valid=1, imm becomes X; the bench flags this as a stimulus error.
- Simultaneous input changes are resolved only at the capture edge; changes between edges have no effect on outputs.
- All flops use the asynchronous-reset template; there is no other state.

Optional Feature:
- Macro: MUX_IMM_SEXT_EN.
- When defined:
  - Adds output port imm_ext, output, EXT_W bits, registered alongside imm.
  - Value: next_imm sign-extended from bit IMM_W-1 to EXT_W bits.
  - Reset value 0.
  - Holds its value when in_valid=0, like imm.
- When undefined:
  - The port and its register are absent.
  - Downstream logic performs the extension itself.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package minirisc_pkg holds:
  - IMM_W=17 and EXT_W=32 constants.
  - Typedef imm_t (logic [IMM_W-1:0]).
  - Enumerated select constants SEL_ITYPE=1'b0 and SEL_MEM=1'b1.
- One natural sub-module: imm_sext, a purely combinational sign-extender, instantiated only under MUX_IMM_SEXT_EN.
- The 2:1 select stays inline.

Test Plan:
1. Reset:
   - Stimulus: assert rst with mem_type=4, I_type=1, in_valid=1; deassert rst between clock edges.
   - Required: imm=0, sel_mem=0, out_valid=0 while rst is high; imm=1 after the first edge following release (I27=0).
2. Alternating select:
   - Stimulus: mem_type=4, I_type=1, in_valid=1; I27 sequence 0, 1, 0 on successive cycles.
   - Required: one cycle later, imm=1, 4, 1; sel_mem=0, 1, 0; out_valid=1 throughout.
3. Hold:
   - Stimulus: capture mem_type=0x1ABCD with I27=1; then in_valid=0 while inputs change to 0x00055.
   - Required: imm stays 0x1ABCD; out_valid=0.
4. Full width:
   - Stimulus: I_type=0x1FFFF, I27=0.
   - Required: imm=0x1FFFF. With MUX_IMM_SEXT_EN, imm_ext=0xFFFFFFFF; with I_type=0x0FFFF, imm_ext=0x0000FFFF.
5. Asynchronous reset mid-stream:
   - Stimulus: pulse rst for 3 ns between edges while out_valid=1.
   - Required: outputs clear at once, without waiting for a clock edge.
6. X isolation:
   - Stimulus: mem_type=X, I_type=7, I27=0.
   - Required: imm=7, no X present on imm.
